// File: rtl/m_seq_checker_32bit.sv
`default_nettype none
// ============================================================================
// Module   : m_seq_checker_32bit
// Brief    : Receive-side checker for the 32-bit Galois m-sequence generator.
//            Hunts for lock, then counts mismatches and checked words.
//            Optional mismatch capture ports: define M_SEQ_CHK_ERR_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module m_seq_checker_32bit #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       din,
    input  logic              din_valid,
    input  logic              clr_cnt,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              zero_state
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
    ,
    output logic [31:0]       err_rx,
    output logic [31:0]       err_exp
`endif
);

    localparam int c_GR_W = $clog2(LOCK_CNT + 1);
    localparam int c_BR_W = $clog2(LOSS_CNT + 1);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // One generator step: shift up, feedback s[31] into bit 0 and the taps.
    function automatic logic [31:0] f_step(input logic [31:0] s);
        logic [31:0] n;
        n[0] = s[31];
        for (int i = 1; i < 32; i++) begin
            if (i == 24 || i == 25 || i == 29 || i == 31)
                n[i] = s[i-1] ^ s[31];
            else
                n[i] = s[i-1];
        end
        return n;
    endfunction

    state_t             r_state,     w_state_nxt;
    logic [31:0]        r_prev,      w_prev_nxt;
    logic               r_have_prev, w_have_prev_nxt;
    logic [c_GR_W-1:0]  r_good_run,  w_good_run_nxt;
    logic [c_BR_W-1:0]  r_bad_run,   w_bad_run_nxt;
    logic [31:0]        r_replica,   w_replica_nxt;
    logic               r_err_pulse, w_err_pulse_nxt;
    logic [CNT_W-1:0]   r_err_cnt,   w_err_cnt_nxt;
    logic [CNT_W-1:0]   r_word_cnt,  w_word_cnt_nxt;
    logic               r_zero,      w_zero_nxt;
    logic               w_err_inc, w_word_inc;
    logic               w_good, w_mismatch;
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
    logic [31:0]        r_err_rx, r_err_exp;
    logic               w_cap;
`endif

    assign w_good     = r_have_prev && (din == f_step(r_prev)) && (din != 32'h0);
    assign w_mismatch = (din != r_replica);

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_have_prev_nxt = r_have_prev;
        w_good_run_nxt  = r_good_run;
        w_bad_run_nxt   = r_bad_run;
        w_replica_nxt   = r_replica;
        w_err_pulse_nxt = 1'b0;
        w_zero_nxt      = r_zero;
        w_err_inc       = 1'b0;
        w_word_inc      = 1'b0;
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
        w_cap           = 1'b0;
`endif
        if (din_valid) begin
            w_zero_nxt = (din == 32'h0);
            if (r_state == ST_HUNT) begin
                w_prev_nxt      = din;
                w_have_prev_nxt = 1'b1;
                if (!w_good) begin
                    w_good_run_nxt = '0;
                end else if (r_good_run == c_GR_W'(LOCK_CNT - 1)) begin
                    w_state_nxt    = ST_LOCK;
                    w_replica_nxt  = f_step(din);
                    w_bad_run_nxt  = '0;
                    w_good_run_nxt = '0;
                end else begin
                    w_good_run_nxt = r_good_run + c_GR_W'(1);
                end
            end else begin
                // Replica free-runs so a single bad word costs one error only.
                w_replica_nxt   = f_step(r_replica);
                w_word_inc      = 1'b1;
                w_err_pulse_nxt = w_mismatch;
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
                w_cap           = w_mismatch;
`endif
                if (!w_mismatch) begin
                    w_bad_run_nxt = '0;
                end else begin
                    w_err_inc = 1'b1;
                    if (r_bad_run == c_BR_W'(LOSS_CNT - 1)) begin
                        w_state_nxt     = ST_HUNT;
                        w_prev_nxt      = din;
                        w_have_prev_nxt = 1'b1;
                        w_good_run_nxt  = '0;
                        w_bad_run_nxt   = '0;
                    end else begin
                        w_bad_run_nxt = r_bad_run + c_BR_W'(1);
                    end
                end
            end
        end

        // Clear wins over a same-cycle increment; counters stick at all-ones.
        w_err_cnt_nxt  = r_err_cnt;
        w_word_cnt_nxt = r_word_cnt;
        if (clr_cnt) begin
            w_err_cnt_nxt  = '0;
            w_word_cnt_nxt = '0;
        end else begin
            if (w_err_inc && (r_err_cnt != {CNT_W{1'b1}}))
                w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
            if (w_word_inc && (r_word_cnt != {CNT_W{1'b1}}))
                w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_HUNT;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_good_run  <= '0;
            r_bad_run   <= '0;
            r_replica   <= '0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_word_cnt  <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_have_prev <= w_have_prev_nxt;
            r_good_run  <= w_good_run_nxt;
            r_bad_run   <= w_bad_run_nxt;
            r_replica   <= w_replica_nxt;
            r_err_pulse <= w_err_pulse_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_zero      <= w_zero_nxt;
        end
    end

`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_rx  <= '0;
            r_err_exp <= '0;
        end else if (w_cap) begin
            r_err_rx  <= din;
            r_err_exp <= r_replica;
        end
    end

    assign err_rx  = r_err_rx;
    assign err_exp = r_err_exp;
`endif

    assign locked     = (r_state == ST_LOCK);
    assign err_pulse  = r_err_pulse;
    assign err_cnt    = r_err_cnt;
    assign word_cnt   = r_word_cnt;
    assign zero_state = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_m_seq_checker_32bit.sv
`default_nettype none
// Testbench for m_seq_checker_32bit: randomized and directed stimulus, a
// behavioural reference model feeding a scoreboard queue, and a monitor.
module tb_m_seq_checker_32bit;

    localparam int LOCK_CNT = 8;
    localparam int LOSS_CNT = 4;
    localparam int CW       = 4;
    localparam int CMAX     = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    din = 32'h0;
    logic           din_valid = 1'b0;
    logic           clr_cnt = 1'b0;
    logic           locked, err_pulse, zero_state;
    logic [CW-1:0]  err_cnt, word_cnt;
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
    logic [31:0]    err_rx, err_exp;
`endif

    m_seq_checker_32bit #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .word_cnt(word_cnt), .zero_state(zero_state)
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
        , .err_rx(err_rx), .err_exp(err_exp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        locked;
        logic        ep;
        int          ec;
        int          wc;
        logic        zs;
        logic [31:0] rx;
        logic [31:0] ex;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    // Reference model state
    bit          m_locked, m_have, m_ep, m_zs;
    logic [31:0] m_prev, m_rep, m_rx, m_ex;
    int          m_gr, m_br, m_ec, m_wc;
    logic [31:0] g;  // generator being checked

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s << 1) ^ (s[31] ? 32'hA300_0001 : 32'h0);
    endfunction

    task automatic model(input logic r, input logic v, input logic [31:0] d, input logic c);
        bit ec_inc = 0, wc_inc = 0;
        if (r) begin
            m_locked = 0; m_have = 0; m_ep = 0; m_zs = 0;
            m_prev = 0; m_rep = 0; m_rx = 0; m_ex = 0;
            m_gr = 0; m_br = 0; m_ec = 0; m_wc = 0;
            return;
        end
        m_ep = 0;
        if (v) begin
            m_zs = (d == 0);
            if (!m_locked) begin
                bit good = m_have && d == step(m_prev) && d != 0;
                m_gr = good ? m_gr + 1 : 0;
                m_prev = d; m_have = 1;
                if (good && m_gr == LOCK_CNT) begin
                    m_locked = 1; m_rep = step(d); m_br = 0;
                end
            end else begin
                logic [31:0] e = m_rep;
                m_rep = step(e);
                wc_inc = 1;
                m_ep = (d != e);
                if (d != e) begin
                    ec_inc = 1; m_br++; m_rx = d; m_ex = e;
                    if (m_br == LOSS_CNT) begin
                        m_locked = 0; m_prev = d; m_have = 1; m_gr = 0;
                    end
                end else begin
                    m_br = 0;
                end
            end
        end
        if (c) begin
            m_ec = 0; m_wc = 0;
        end else begin
            if (ec_inc && m_ec < CMAX) m_ec++;
            if (wc_inc && m_wc < CMAX) m_wc++;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic c);
        exp_t e;
        @(negedge clk);
        rst = r; din_valid = v; din = d; clr_cnt = c;
        model(r, v, d, c);
        e.locked = m_locked; e.ep = m_ep; e.ec = m_ec; e.wc = m_wc; e.zs = m_zs;
        e.rx = m_rx; e.ex = m_ex;
        q.push_back(e);
    endtask

    task automatic gen_word(input logic [31:0] mask, input logic c);
        drive(1'b0, 1'b1, g ^ mask, c);
        g = step(g);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        g = 32'h1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, expv);
        end
    endtask

    // Monitor: outputs are registered every cycle, so one entry per clock.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",     32'(locked),     32'(e.locked));
                chk("err_pulse",  32'(err_pulse),  32'(e.ep));
                chk("err_cnt",    32'(err_cnt),    32'(e.ec));
                chk("word_cnt",   32'(word_cnt),   32'(e.wc));
                chk("zero_state", 32'(zero_state), 32'(e.zs));
`ifdef M_SEQ_CHK_ERR_CAPTURE_EN
                chk("err_rx",     err_rx,          e.rx);
                chk("err_exp",    err_exp,         e.ex);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: clean stream locks after the 9th word
        do_reset();
        for (int i = 0; i < 30; i++) gen_word(32'h0, 1'b0);
        // 2: single flipped bit
        gen_word(32'h20, 1'b0);
        for (int i = 0; i < 6; i++) gen_word(32'h0, 1'b0);
        // 3: four consecutive bad words drop lock, then relock
        for (int i = 0; i < 4; i++) gen_word(32'h1 << (i + 3), 1'b0);
        for (int i = 0; i < 20; i++) gen_word(32'h0, 1'b0);
        // 4: din_valid toggling with garbage on idle cycles (reset while locked)
        do_reset();
        for (int i = 0; i < 50; i++) begin
            drive(1'b0, 1'b0, $urandom, 1'b0);
            gen_word(32'h0, 1'b0);
        end
        // 5: all-zero stream must never lock
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 32'h0, 1'b0);
        // 6: clear coincident with a mismatch, then saturation
        do_reset();
        for (int i = 0; i < 10; i++) gen_word(32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            gen_word(32'h100, 1'b0);
            gen_word(32'h0, 1'b0);
        end
        gen_word(32'h8000_0000, 1'b1);
        for (int i = 0; i < 20; i++) gen_word(32'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            gen_word(32'h4, 1'b0);
            gen_word(32'h0, 1'b0);
        end
        // Random phase
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 999);
            logic c = ($urandom_range(0, 39) == 0);
            if (r < 3) begin
                do_reset();
            end else if (r < 250) begin
                drive(1'b0, 1'b0, $urandom, c);
            end else if (r < 330) begin
                gen_word(32'h1 << $urandom_range(0, 31), c);
            end else if (r < 335) begin
                for (int k = 0; k < 5; k++) gen_word(32'h1 << $urandom_range(0, 31), 1'b0);
            end else if (r < 338) begin
                drive(1'b0, 1'b1, 32'h0, c);
            end else begin
                gen_word(32'h0, c);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
